// File: rtl/mem_bus_router.sv
// rtl/mem_bus_router.sv - single-outstanding memory-bus target decoding SDRAM/IO/ROM regions
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous active-low reset
//   bus_addr   in   27  request address from the arbiter
//   bus_data   in   32  write data from the arbiter
//   bus_we     in   1   1 = write, 0 = read
//   bus_start  in   1   request valid, only looked at in IDLE
//   bus_q      out  32  read data, valid while bus_done=1
//   bus_done   out  1   one-cycle completion pulse
//   bus_err    out  1   one-cycle error pulse, coincident with bus_done
//   dev_addr   out  27  region-relative offset, shared by all slaves
//   dev_data   out  32  latched write data, shared
//   dev_we     out  1   latched write enable, shared
//   dev_start  out  3   one-hot start pulse (bit0 SDRAM, bit1 IO, bit2 ROM)
//   dev_q0/1/2 in   32  slave read data, valid with the matching dev_done bit
//   dev_done   in   3   slave completion pulses
module mem_bus_router #(
  parameter logic [26:0] S0_END     = 27'h0800000,
  parameter logic [26:0] S1_BASE    = 27'h0800000,
  parameter logic [26:0] S1_END     = 27'h0C00000,
  parameter logic [26:0] S2_BASE    = 27'h0C00000,
  parameter logic [26:0] S2_END     = 27'h0C00400,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] UNMAPPED_Q = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] bus_addr,
  input  logic [31:0] bus_data,
  input  logic        bus_we,
  input  logic        bus_start,
  output logic [31:0] bus_q,
  output logic        bus_done,
  output logic        bus_err,
  output logic [26:0] dev_addr,
  output logic [31:0] dev_data,
  output logic        dev_we,
  output logic [2:0]  dev_start,
  input  logic [31:0] dev_q0,
  input  logic [31:0] dev_q1,
  input  logic [31:0] dev_q2,
  input  logic [2:0]  dev_done
);

  localparam int             CW   = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    sel, sel_n;

  logic [31:0] bus_q_n;
  logic        bus_done_n, bus_err_n;
  logic [26:0] dev_addr_n;
  logic [31:0] dev_data_n;
  logic        dev_we_n;
  logic [2:0]  dev_start_n;

  // Address decode, first match wins (SDRAM, then IO, then ROM).
  logic        dec_hit;
  logic [1:0]  dec_sel;
  logic [26:0] dec_base;

  always_comb begin
    dec_hit  = 1'b1;
    dec_sel  = 2'd0;
    dec_base = '0;
    if (bus_addr < S0_END) begin
      dec_sel  = 2'd0;
      dec_base = '0;
    end else if (bus_addr >= S1_BASE && bus_addr < S1_END) begin
      dec_sel  = 2'd1;
      dec_base = S1_BASE;
    end else if (bus_addr >= S2_BASE && bus_addr < S2_END) begin
      dec_sel  = 2'd2;
      dec_base = S2_BASE;
    end else begin
      dec_hit  = 1'b0;
    end
  end

  // Only the selected slave's completion and data are visible; others are ignored.
  logic        sel_done;
  logic [31:0] sel_q;

  always_comb begin
    sel_done = 1'b0;
    sel_q    = dev_q0;
    case (sel)
      2'd0: begin sel_done = dev_done[0]; sel_q = dev_q0; end
      2'd1: begin sel_done = dev_done[1]; sel_q = dev_q1; end
      2'd2: begin sel_done = dev_done[2]; sel_q = dev_q2; end
      default: ;
    endcase
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sel_n       = sel;
    bus_q_n     = bus_q;
    bus_done_n  = 1'b0;
    bus_err_n   = 1'b0;
    dev_addr_n  = dev_addr;
    dev_data_n  = dev_data;
    dev_we_n    = dev_we;
    dev_start_n = 3'b000;
    case (state)
      IDLE: begin
        if (bus_start) begin
          if (dec_hit) begin
            sel_n       = dec_sel;
            dev_addr_n  = bus_addr - dec_base;
            dev_data_n  = bus_data;
            dev_we_n    = bus_we;
            dev_start_n = 3'b001 << dec_sel;
            cnt_n       = '0;
            state_n     = REQ;
          end else begin
            bus_q_n    = UNMAPPED_Q;
            bus_done_n = 1'b1;
            bus_err_n  = 1'b1;
            state_n    = DONE;
          end
        end
      end
      REQ: begin
        // Counter tracks REQ+WAIT cycles spent; REQ is cycle 0.
        cnt_n = cnt + ONE;
        if (sel_done) begin
          bus_q_n    = sel_q;
          bus_done_n = 1'b1;
          state_n    = DONE;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt + ONE;
        if (sel_done) begin
          bus_q_n    = sel_q;
          bus_done_n = 1'b1;
          state_n    = DONE;
        end else if (cnt == LAST) begin
          bus_q_n    = UNMAPPED_Q;
          bus_done_n = 1'b1;
          bus_err_n  = 1'b1;
          state_n    = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= 2'd0;
      bus_q     <= '0;
      bus_done  <= 1'b0;
      bus_err   <= 1'b0;
      dev_addr  <= '0;
      dev_data  <= '0;
      dev_we    <= 1'b0;
      dev_start <= 3'b000;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sel       <= sel_n;
      bus_q     <= bus_q_n;
      bus_done  <= bus_done_n;
      bus_err   <= bus_err_n;
      dev_addr  <= dev_addr_n;
      dev_data  <= dev_data_n;
      dev_we    <= dev_we_n;
      dev_start <= dev_start_n;
    end
  end

endmodule
